// File: rtl/reaction_display.sv
// reaction_display: captures a 14-bit reaction value, converts it to four BCD
// digits with a sequential shift-add-3 engine, and scans the result onto an
// active-low, time-multiplexed 4-digit 7-segment display.
//
// Optional build macro: REACTION_DISPLAY_LZB_EN enables leading-zero blanking.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for load; display register holds the last result
// CONV  | shifting the captured value through the BCD accumulator
module reaction_display #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        areset,
  input  logic [13:0] value,
  input  logic        load,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [19:0] SCAN_TC  = 20'(SCAN_DIV - 1);

  typedef enum logic {IDLE, CONV} state_t;

  state_t      state, state_nxt;
  logic        capture, shift, last;
  logic [13:0] shreg;
  logic [15:0] bcd;
  logic [15:0] bcd_adj;
  logic [3:0]  iter;
  logic        ovf;
  logic        done;
  logic [15:0] disp;
  logic        disp_dash;
  logic [15:0] disp_nxt;
  logic        dash_nxt;
  logic [19:0] scan_cnt;
  logic [1:0]  dig;
  logic [1:0]  dig_nxt;
  logic        scan_tc;

  function automatic logic [15:0] add3(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Segment pattern for digit position pos of BCD word d.
  function automatic logic [6:0] digit_code(input logic [1:0] pos,
                                            input logic [15:0] d,
                                            input logic dash);
    logic [6:0] s;
    s = seg7(d[{pos, 2'b00} +: 4]);
`ifdef REACTION_DISPLAY_LZB_EN
    // A digit is blanked while it and every higher digit are zero.
    if ((pos == 2'd3 && d[15:12] == 4'd0) ||
        (pos == 2'd2 && d[15:8]  == 8'd0) ||
        (pos == 2'd1 && d[15:4]  == 12'd0))
      s = SEG_BLANK;
`endif
    if (dash) s = SEG_DASH;
    return s;
  endfunction

  assign busy    = (state == CONV);
  assign bcd_adj = add3(bcd);

  // FSM state register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and datapath strobes.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    shift     = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          capture   = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        shift = 1'b1;
        if (iter == 4'd13) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion datapath: capture, then 14 add-3-and-shift steps.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      shreg <= '0;
      bcd   <= '0;
      iter  <= '0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (capture) begin
        shreg <= value;
        bcd   <= '0;
        iter  <= '0;
        ovf   <= (value >= 14'd10000);
      end else if (shift) begin
        bcd   <= {bcd_adj[14:0], shreg[13]};
        shreg <= {shreg[12:0], 1'b0};
        iter  <= iter + 4'd1;
      end
    end
  end

  // The display register is written only once the conversion has finished,
  // so partial results never reach the segments.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      disp      <= '0;
      disp_dash <= 1'b0;
    end else if (done) begin
      disp      <= bcd;
      disp_dash <= ovf;
    end
  end

  assign disp_nxt = done ? bcd : disp;
  assign dash_nxt = done ? ovf : disp_dash;
  assign scan_tc  = (scan_cnt == SCAN_TC);
  assign dig_nxt  = dig + 2'd1;

  // Free-running digit scan; a completing write on the advance edge is
  // forwarded so the new digit shows immediately.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      scan_cnt <= '0;
      dig      <= '0;
      an       <= 4'b1110;
      seg      <= SEG_ZERO;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      dig      <= dig_nxt;
      an       <= ~(4'b0001 << dig_nxt);
      seg      <= digit_code(dig_nxt, disp_nxt, dash_nxt);
    end else begin
      scan_cnt <= scan_cnt + 20'd1;
    end
  end

endmodule
